unified_mem_arbiter: RTL

//  Shares one synchronous single-port word RAM between the CPU instruction-fetch port (rom_*)
//  and the CPU data port (mem_*). Sequences each access: grant, one-cycle RAM strobe, wait states, ready pulse.

---
 rtl/unified_mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one synchronous single-port word RAM between the CPU
//               instruction-fetch port and the CPU data port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_mem_arbiter #(
  parameter int               AW         = 32,
  parameter int               DW         = 32,
  parameter int               DEPTH_LOG2 = 7,
  parameter logic [AW-1:0]    BASE_ADDR  = 'h0040_0000,
  parameter int               WAIT_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  rom_req,
  input  logic [AW-1:0]         rom_addr,
  output logic [DW-1:0]         rom_rdata,
  output logic                  rom_rdy,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_wdata,
  output logic [DW-1:0]         mem_rdata,
  output logic                  mem_rdy,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic [DW-1:0]         ram_wdata,
  input  logic [DW-1:0]         ram_rdata
);

  localparam int          CW   = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [AW:0] C_LO = {1'b0, BASE_ADDR};
  localparam logic [AW:0] C_HI = C_LO + ((AW+1)'(4) << DEPTH_LOG2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_owner_mem;
  logic                    r_last_mem;
  logic                    r_we;
  logic [DEPTH_LOG2-1:0]   r_waddr;
  logic [DW-1:0]           r_wdata;
  logic [CW-1:0]           r_cnt;

  logic                    w_any_req;
  logic                    w_grant_mem;
  logic [AW-1:0]           w_addr;
  logic                    w_in_range;
  logic [DEPTH_LOG2-1:0]   w_word;

  // On a tie the port that did not win last time is served.
  assign w_any_req   = rom_req | mem_req;
  assign w_grant_mem = mem_req & (~rom_req | ~r_last_mem);
  assign w_addr      = w_grant_mem ? mem_addr : rom_addr;
  assign w_in_range  = ({1'b0, w_addr} >= C_LO) && ({1'b0, w_addr} < C_HI);
  assign w_word      = DEPTH_LOG2'((w_addr - BASE_ADDR) >> 2);

  assign ram_addr  = r_waddr;
  assign ram_wdata = r_wdata;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    rom_rdy     = 1'b0;
    mem_rdy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_in_range ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        ram_cs      = 1'b1;
        ram_we      = r_we;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rom_rdy     = ~r_owner_mem;
        mem_rdy     = r_owner_mem;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_owner_mem <= 1'b0;
      r_last_mem  <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      rom_rdata   <= '0;
      mem_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner_mem <= w_grant_mem;
            r_last_mem  <= w_grant_mem;
            r_we        <= w_grant_mem & mem_we;
            r_waddr     <= w_word;
            r_wdata     <= mem_wdata;
            // Out-of-range accesses skip the RAM and complete with zero data.
            if (!w_in_range) begin
              if (w_grant_mem) mem_rdata <= '0;
              else             rom_rdata <= '0;
            end
          end
        end
        ST_ISSUE: r_cnt <= CW'(WAIT_CYC - 1);
        ST_WAIT: begin
          if (r_cnt == '0) begin
            if (r_owner_mem) mem_rdata <= ram_rdata;
            else             rom_rdata <= ram_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
